// File: rtl/truth_table_checker.sv
// Checks an observed 4-input boolean function against an expected minterm mask.
// It tracks which minterms have been exercised and records mismatches for each run.
module truth_table_checker (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] minterm_mask,
  input  logic        sample_valid,
  input  logic        x,
  input  logic        y,
  input  logic        w,
  input  logic        z,
  input  logic        s,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [15:0] coverage,
  output logic        first_err_valid,
  output logic [3:0]  first_err_idx
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [15:0] mask_reg;
  logic [3:0]  idx;
  logic        expected;
  logic        mismatch;
  logic        take;
  logic [15:0] cov_next;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  always_comb begin
    idx      = {x, y, w, z};
    expected = mask_reg[idx];
    mismatch = (s != expected);
    // start takes priority, so a colliding sample never reaches the run state
    take     = (state == RUN) && sample_valid && !start;
    cov_next = coverage | (16'h0001 << idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      mask_reg        <= 16'h0000;
      coverage        <= 16'h0000;
      err_count       <= 5'd0;
      first_err_valid <= 1'b0;
      first_err_idx   <= 4'd0;
    end else if (start) begin
      state           <= RUN;
      mask_reg        <= minterm_mask;
      coverage        <= 16'h0000;
      err_count       <= 5'd0;
      first_err_valid <= 1'b0;
      first_err_idx   <= 4'd0;
    end else if (take) begin
      coverage <= cov_next;
      if (mismatch) begin
        err_count <= sat_inc(err_count);
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_idx   <= idx;
        end
      end
      if (cov_next == 16'hFFFF) state <= DONE;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (err_count == 5'd0);

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker with hand-computed expectations.
module tb_truth_table_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] minterm_mask;
  logic        sample_valid;
  logic        x, y, w, z, s;
  logic        busy, done, pass;
  logic [4:0]  err_count;
  logic [15:0] coverage;
  logic        first_err_valid;
  logic [3:0]  first_err_idx;

  int total  = 0;
  int passed = 0;

  truth_table_checker dut (
    .clk(clk), .reset(reset), .start(start), .minterm_mask(minterm_mask),
    .sample_valid(sample_valid), .x(x), .y(y), .w(w), .z(z), .s(s),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .coverage(coverage), .first_err_valid(first_err_valid),
    .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      passed++;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] m);
    start = 1'b1;
    minterm_mask = m;
    cycle();
    start = 1'b0;
  endtask

  task automatic sample(input logic [3:0] i, input logic sv);
    sample_valid = 1'b1;
    {x, y, w, z} = i;
    s = sv;
    cycle();
    sample_valid = 1'b0;
  endtask

  // Ascending samples first..last with correct s, except s inverted at flip.
  task automatic sweep(input logic [15:0] m, input int flip, input int first, input int last);
    for (int i = first; i <= last; i++)
      sample(i[3:0], m[i] ^ (i == flip));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_cov"}, coverage, 0);
    check({tag, "_fev"}, first_err_valid, 0);
    check({tag, "_fei"}, first_err_idx, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; minterm_mask = 16'h0; sample_valid = 1'b0;
    x = 0; y = 0; w = 0; z = 0; s = 0;
    repeat (3) cycle();
    check_zero("reset");
    reset = 1'b0;
    cycle();
    sample(4'd3, 1'b1);
    check("idle_ignore_cov", coverage, 16'h0000);
    check("idle_ignore_busy", busy, 0);

    // Pass case
    do_start(16'h15A6);
    check("run_busy", busy, 1);
    sweep(16'h15A6, 99, 0, 14);
    check("pass_15_done", done, 0);
    check("pass_15_cov", coverage, 16'h7FFF);
    sweep(16'h15A6, 99, 15, 15);
    check("pass_done", done, 1);
    check("pass_busy", busy, 0);
    check("pass_pass", pass, 1);
    check("pass_err", err_count, 0);
    check("pass_cov", coverage, 16'hFFFF);
    sample(4'd1, 1'b0);
    check("done_hold_err", err_count, 0);
    check("done_hold_pass", pass, 1);

    // Single error at idx 7
    do_start(16'h15A6);
    sweep(16'h15A6, 7, 0, 15);
    check("err1_done", done, 1);
    check("err1_pass", pass, 0);
    check("err1_err", err_count, 1);
    check("err1_fei", first_err_idx, 7);
    check("err1_fev", first_err_valid, 1);

    // Restart from DONE with all-zero mask
    do_start(16'h0000);
    check("rst_clear_err", err_count, 0);
    check("rst_clear_cov", coverage, 0);
    check("rst_clear_fev", first_err_valid, 0);
    check("rst_clear_done", done, 0);
    sweep(16'h0000, 99, 0, 15);
    check("restart_pass", pass, 1);
    check("restart_err", err_count, 0);

    // Duplicates and saturation at idx 0 (expected 0, drive 1)
    do_start(16'h15A6);
    for (int k = 0; k < 30; k++) sample(4'd0, 1'b1);
    check("sat_30", err_count, 30);
    for (int k = 0; k < 10; k++) sample(4'd0, 1'b1);
    check("sat_err", err_count, 31);
    check("sat_cov", coverage, 16'h0001);
    check("sat_busy", busy, 1);
    check("sat_done", done, 0);
    check("sat_fei", first_err_idx, 0);
    sample(4'd5, 1'b0);
    check("sat_hold_err", err_count, 31);
    check("sat_keep_fei", first_err_idx, 0);
    check("sat_cov2", coverage, 16'h0021);

    // Collision: start with a sample in the same cycle
    sample_valid = 1'b1; {x, y, w, z} = 4'd3; s = 1'b0;
    do_start(16'h15A6);
    sample_valid = 1'b0;
    check("coll_cov", coverage, 0);
    check("coll_busy", busy, 1);
    check("coll_err", err_count, 0);

    // Reset mid-run after 9 samples
    do_start(16'h15A6);
    sweep(16'h15A6, 2, 0, 8);
    check("pre_reset_cov", coverage, 16'h01FF);
    check("pre_reset_err", err_count, 1);
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    #2;
    reset = 1'b0;
    cycle();
    sweep(16'h0000, 99, 0, 15);
    check("post_reset_cov", coverage, 0);
    check("post_reset_busy", busy, 0);
    check("post_reset_done", done, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising-edge) and reset.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous active-high reset; forces the reset state immediately.
REQ-004 start  input  1  single-cycle request to begin a new check run.
REQ-005 minterm_mask  input  16  expected function; bit i = 1 means minterm i is in the sum of minterms.
REQ-006 sample_valid  input  1  qualifies x, y, w, z, s this cycle.
REQ-007 x, y, w, z  input  1 each  observed input combination; x is the MSB, so idx = {x,y,w,z}.
REQ-008 s  input  1  observed function output for that combination.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  high while in DONE.
REQ-011 pass  output  1  high in DONE when err_count == 0.
REQ-012 err_count  output  5  count of mismatching samples, saturating.
REQ-013 coverage  output  16  bit i is set once minterm index i has been sampled.
REQ-014 first_err_valid  output  1  a mismatch has been recorded this run.
REQ-015 first_err_idx  output  4  index of the first mismatching sample.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 In any state, start SHALL load minterm_mask into an internal register, clear coverage, err_count and first_err_valid/first_err_idx, and enter RUN on the next edge.
REQ-018 In IDLE or DONE, sample_valid without start SHALL be ignored.
REQ-019 In RUN, on each sample_valid, expected SHALL equal mask_reg[idx].
REQ-020 On such a sample, coverage[idx] SHALL be set on the next edge.
REQ-021 On such a sample, if s != expected, err_count SHALL increment by 1, saturating at 31.
REQ-022 A repeated idx SHALL be checked and counted again; coverage is unchanged.
REQ-023 On the first mismatch of a run, first_err_idx SHALL capture idx and first_err_valid SHALL go high; later mismatches SHALL NOT overwrite them.
REQ-024 When coverage including the current sample becomes 16'hFFFF, the FSM SHALL enter DONE on that same edge, so done rises one cycle after the 16th distinct sample.
REQ-025 If start and sample_valid occur in the same cycle, start SHALL win and the sample SHALL be discarded.
REQ-026 All outputs SHALL be registered or decoded from registered state only, with no combinational path from any input.
REQ-027 busy, done and pass SHALL be mutually consistent: pass implies done, and busy and done are never both high.
REQ-028 The state SHALL stay in DONE, with all outputs held, until start or reset.

Reset
REQ-029 Asserting reset SHALL immediately force IDLE with busy = 0, done = 0, pass = 0, err_count = 0, coverage = 0, first_err_valid = 0, first_err_idx = 0 and mask_reg = 0.
REQ-030 Reset asserted mid-run SHALL abandon the run with no partial results retained.
REQ-031 After reset deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-032 Pass case: mask = 16'h15A6 (minterms 1, 2, 5, 7, 8, 10, 12), start, then 16 ascending samples with correct s -> done = 1 one cycle after the 16th sample, pass = 1, err_count = 0, coverage = FFFF.
REQ-033 Single error: same sweep with s inverted at idx 7 -> pass = 0, err_count = 1, first_err_idx = 7, first_err_valid = 1.
REQ-034 Duplicates and saturation: 40 wrong samples at idx 0 -> coverage = 0001, err_count = 31, busy = 1, done = 0.
REQ-035 Collision: start and sample_valid in the same cycle -> sample discarded, coverage = 0, state RUN.
REQ-036 Reset: reset asserted after 9 samples -> all outputs zero immediately; samples after reset deasserts are ignored until start.
REQ-037 Restart: start asserted in DONE with mask = 16'h0000 and all s = 0 -> new run passes and previous results are cleared.
